// File: rtl/note_lane_pkg.sv
// note_lane_pkg -- shared constants for the note lane engine.
//   Coordinate widths for the scan position and note positions, the default
//   playfield geometry, and the lane color table used by the renderer.
package note_lane_pkg;

  localparam int X_W   = 10;  // scan x width
  localparam int Y_W   = 9;   // scan y width
  localparam int POS_W = 10;  // note top-edge position width
  localparam int CMP_W = 11;  // geometry compare width, wide enough for pos + NOTE_H

  localparam int DEF_LANE_X0    = 170;
  localparam int DEF_LANE_PITCH = 100;
  localparam int DEF_NOTE_W     = 50;
  localparam int DEF_NOTE_H     = 50;
  localparam int DEF_SCREEN_H   = 480;
  localparam int DEF_SPEED      = 1;
  localparam int DEF_HIT_Y      = 400;
  localparam int DEF_HIT_WIN    = 40;

  typedef logic [23:0] rgb_t;

  // Lane color table (24-bit RGB), wraps every four lanes.
  function automatic rgb_t lane_color(input int lane);
    case (lane % 4)
      0:       lane_color = 24'h20C020;
      1:       lane_color = 24'hE02020;
      2:       lane_color = 24'hE0E020;
      default: lane_color = 24'h2040E0;
    endcase
  endfunction

endpackage

// File: rtl/note_lane.sv
// note_lane -- one lane of falling notes.
//   Holds SLOTS notes (valid bit + 10-bit top-edge y). Each cycle it may
//   allocate a spawned note, move notes on frame_tick, resolve a strike
//   against the hit window and retire notes that leave the screen.
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   frame_tick       advance all live notes by SPEED
//   x, y             scan position, used for the registered pixel_hit
//   spawn            allocate a new note at y=0 (caller guarantees has_free)
//   strike           player struck this lane this cycle
//   has_free         at least one slot is free (pre-update state)
//   pixel_hit        registered: scan pixel lies inside a live note
//   hit_pulse        one-cycle pulse: a strike cleared a note
//   miss_pulse       one-cycle pulse: a note fell off the screen
module note_lane
  import note_lane_pkg::*;
#(
  parameter int SLOTS    = 8,
  parameter int LANE_X   = DEF_LANE_X0,
  parameter int NOTE_W   = DEF_NOTE_W,
  parameter int NOTE_H   = DEF_NOTE_H,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int SPEED    = DEF_SPEED,
  parameter int HIT_Y    = DEF_HIT_Y,
  parameter int HIT_WIN  = DEF_HIT_WIN
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           frame_tick,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic           spawn,
  input  logic           strike,
  output logic           has_free,
  output logic           pixel_hit,
  output logic           hit_pulse,
  output logic           miss_pulse
);

  logic [SLOTS-1:0] valid_q, valid_d;
  logic [POS_W-1:0] pos_q [SLOTS];
  logic [POS_W-1:0] pos_d [SLOTS];

  logic [SLOTS-1:0] alloc_oh, strike_oh;
  logic             alloc_found, strike_found;
  logic [POS_W-1:0] best_y;
  logic             miss_any, pixel_d;
  logic [CMP_W-1:0] moved, xe, ye, pe;

  assign has_free = ~&valid_q;

  // Slot selection on pre-update state: lowest free slot for allocation,
  // live slot with the largest y inside the hit window for the strike.
  always_comb begin
    alloc_oh     = '0;
    alloc_found  = 1'b0;
    strike_oh    = '0;
    strike_found = 1'b0;
    best_y       = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (!valid_q[s] && !alloc_found) begin
        alloc_found = 1'b1;
        alloc_oh[s] = 1'b1;
      end
      if (valid_q[s] &&
          {1'b0, pos_q[s]} >= CMP_W'(HIT_Y) &&
          {1'b0, pos_q[s]} <  CMP_W'(HIT_Y + HIT_WIN) &&
          (!strike_found || pos_q[s] > best_y)) begin
        strike_found = 1'b1;
        best_y       = pos_q[s];
        strike_oh    = '0;
        strike_oh[s] = 1'b1;
      end
    end
  end

  // Per-slot update. A struck slot is retired before any movement, and a
  // freshly allocated slot was free this cycle so it is never moved.
  always_comb begin
    miss_any = 1'b0;
    pixel_d  = 1'b0;
    moved    = '0;
    xe       = {1'b0, x};
    ye       = {2'b00, y};
    pe       = '0;
    for (int s = 0; s < SLOTS; s++) begin
      valid_d[s] = valid_q[s];
      pos_d[s]   = pos_q[s];
      moved      = {1'b0, pos_q[s]} + CMP_W'(SPEED);
      pe         = {1'b0, pos_q[s]};
      if (valid_q[s]) begin
        if (strike && strike_oh[s]) begin
          valid_d[s] = 1'b0;
          pos_d[s]   = '0;
        end else if (frame_tick) begin
          if (moved >= CMP_W'(SCREEN_H)) begin
            valid_d[s] = 1'b0;
            pos_d[s]   = '0;
            miss_any   = 1'b1;
          end else begin
            pos_d[s] = moved[POS_W-1:0];
          end
        end
        if (xe >= CMP_W'(LANE_X) && xe < CMP_W'(LANE_X + NOTE_W) &&
            ye >= pe && ye < pe + CMP_W'(NOTE_H)) begin
          pixel_d = 1'b1;
        end
      end else if (spawn && alloc_oh[s]) begin
        valid_d[s] = 1'b1;
        pos_d[s]   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= '0;
      for (int s = 0; s < SLOTS; s++) pos_q[s] <= '0;
      pixel_hit  <= 1'b0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      for (int s = 0; s < SLOTS; s++) pos_q[s] <= pos_d[s];
      pixel_hit  <= pixel_d;
      hit_pulse  <= strike && strike_found;
      miss_pulse <= miss_any;
    end
  end

endmodule

// File: rtl/note_lane_engine.sv
// note_lane_engine -- rhythm-game note field with LANES lanes.
//   Spawns notes, scrolls them down on frame_tick, resolves player strikes in
//   the hit window, reports misses and renders a per-lane pixel mask.
// Optional feature: define NOTE_LANE_SCORE_EN to enable the saturating score
//   counter; otherwise score is tied to 0.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   frame_tick                 one-cycle pulse per frame
//   x [10], y [9]              scan position
//   spawn_valid, spawn_mask    spawn request and target lanes
//   spawn_ready                every lane has a free slot
//   strike_valid, strike_mask  player strike and struck lanes
//   pixel_lane                 registered per-lane pixel coverage
//   hit_pulse, miss_pulse      per-lane one-cycle event pulses
//   score [16]                 hit counter (feature build only)
// Handshake: a spawn is accepted in any cycle where spawn_valid && spawn_ready;
//   spawn_ready depends only on slot occupancy, never on spawn_valid/mask.
module note_lane_engine
  import note_lane_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int SLOTS      = 8,
  parameter int LANE_X0    = DEF_LANE_X0,
  parameter int LANE_PITCH = DEF_LANE_PITCH,
  parameter int NOTE_W     = DEF_NOTE_W,
  parameter int NOTE_H     = DEF_NOTE_H,
  parameter int SCREEN_H   = DEF_SCREEN_H,
  parameter int SPEED      = DEF_SPEED,
  parameter int HIT_Y      = DEF_HIT_Y,
  parameter int HIT_WIN    = DEF_HIT_WIN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic [X_W-1:0]   x,
  input  logic [Y_W-1:0]   y,
  input  logic             spawn_valid,
  input  logic [LANES-1:0] spawn_mask,
  output logic             spawn_ready,
  input  logic             strike_valid,
  input  logic [LANES-1:0] strike_mask,
  output logic [LANES-1:0] pixel_lane,
  output logic [LANES-1:0] hit_pulse,
  output logic [LANES-1:0] miss_pulse,
  output logic [15:0]      score
);

  logic [LANES-1:0] has_free;
  logic             spawn_fire;

  assign spawn_ready = &has_free;
  assign spawn_fire  = spawn_valid && spawn_ready;

  for (genvar l = 0; l < LANES; l++) begin : gen_lane
    note_lane #(
      .SLOTS    (SLOTS),
      .LANE_X   (LANE_X0 + l * LANE_PITCH),
      .NOTE_W   (NOTE_W),
      .NOTE_H   (NOTE_H),
      .SCREEN_H (SCREEN_H),
      .SPEED    (SPEED),
      .HIT_Y    (HIT_Y),
      .HIT_WIN  (HIT_WIN)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .x          (x),
      .y          (y),
      .spawn      (spawn_fire && spawn_mask[l]),
      .strike     (strike_valid && strike_mask[l]),
      .has_free   (has_free[l]),
      .pixel_hit  (pixel_lane[l]),
      .hit_pulse  (hit_pulse[l]),
      .miss_pulse (miss_pulse[l])
    );
  end

`ifdef NOTE_LANE_SCORE_EN
  logic [15:0] hit_count;
  logic [16:0] score_sum;

  always_comb begin
    hit_count = '0;
    for (int l = 0; l < LANES; l++) hit_count = hit_count + 16'(hit_pulse[l]);
    score_sum = {1'b0, score} + {1'b0, hit_count};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) score <= '0;
    else        score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end
`else
  assign score = '0;
`endif

endmodule

// File: tb/tb_note_lane_engine.sv
// tb_note_lane_engine -- self-checking bench for note_lane_engine.
//   Notes are modelled per lane as an unordered list of y positions; each
//   cycle the model applies strike, movement/miss and spawn rules and pushes
//   the expected {pixel_lane, hit_pulse, miss_pulse, spawn_ready} word.
module tb_note_lane_engine;

  localparam int LANES = 4, SLOTS = 8;
  localparam int LANE_X0 = 170, LANE_PITCH = 100, NOTE_W = 50, NOTE_H = 50;
  localparam int SCREEN_H = 480, SPEED = 1, HIT_Y = 400, HIT_WIN = 40;
  localparam int W = 3 * LANES + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             frame_tick, spawn_valid, strike_valid, spawn_ready;
  logic [9:0]       x;
  logic [8:0]       y;
  logic [LANES-1:0] spawn_mask, strike_mask, pixel_lane, hit_pulse, miss_pulse;
  logic [15:0]      score;

  note_lane_engine #(.LANES(LANES), .SLOTS(SLOTS)) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .x            (x),
    .y            (y),
    .spawn_valid  (spawn_valid),
    .spawn_mask   (spawn_mask),
    .spawn_ready  (spawn_ready),
    .strike_valid (strike_valid),
    .strike_mask  (strike_mask),
    .pixel_lane   (pixel_lane),
    .hit_pulse    (hit_pulse),
    .miss_pulse   (miss_pulse),
    .score        (score)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int               npos[LANES][SLOTS];
  int               ncnt[LANES];
  logic [LANES-1:0] m_hit, m_miss, m_pix;
  int               m_score;

  task automatic model_clear();
    for (int l = 0; l < LANES; l++) ncnt[l] = 0;
    m_hit = '0; m_miss = '0; m_pix = '0; m_score = 0;
    exp_q.delete();
  endtask

  task automatic model_remove(input int l, input int k);
    npos[l][k] = npos[l][ncnt[l] - 1];
    ncnt[l]--;
  endtask

  task automatic model_cycle(input logic sv, input logic [LANES-1:0] sm, input logic stv,
                             input logic [LANES-1:0] stm, input logic ft, input int px, input int py);
    int best, k, lx;
    logic ready_pre, ready_post;
    m_pix = '0;
    for (int l = 0; l < LANES; l++) begin
      lx = LANE_X0 + l * LANE_PITCH;
      for (int j = 0; j < ncnt[l]; j++)
        if (px >= lx && px < lx + NOTE_W && py >= npos[l][j] && py < npos[l][j] + NOTE_H)
          m_pix[l] = 1'b1;
    end
`ifdef NOTE_LANE_SCORE_EN
    m_score = m_score + $countones(m_hit);
    if (m_score > 65535) m_score = 65535;
`endif
    ready_pre = 1'b1;
    for (int l = 0; l < LANES; l++) if (ncnt[l] >= SLOTS) ready_pre = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      m_hit[l] = 1'b0;
      m_miss[l] = 1'b0;
      if (stv && stm[l]) begin
        best = -1;
        for (int j = 0; j < ncnt[l]; j++)
          if (npos[l][j] >= HIT_Y && npos[l][j] < HIT_Y + HIT_WIN &&
              (best < 0 || npos[l][j] > npos[l][best])) best = j;
        if (best >= 0) begin
          model_remove(l, best);
          m_hit[l] = 1'b1;
        end
      end
      if (ft) begin
        k = 0;
        while (k < ncnt[l]) begin
          npos[l][k] += SPEED;
          if (npos[l][k] >= SCREEN_H) begin
            model_remove(l, k);
            m_miss[l] = 1'b1;
          end else k++;
        end
      end
      if (sv && ready_pre && sm[l]) begin
        npos[l][ncnt[l]] = 0;
        ncnt[l]++;
      end
    end
    ready_post = 1'b1;
    for (int l = 0; l < LANES; l++) if (ncnt[l] >= SLOTS) ready_post = 1'b0;
    exp_q.push_back({m_pix, m_hit, m_miss, ready_post});
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic sv, input logic [LANES-1:0] sm, input logic stv,
                       input logic [LANES-1:0] stm, input logic ft, input int px, input int py);
    logic [W-1:0] e;
    spawn_valid = sv; spawn_mask = sm; strike_valid = stv; strike_mask = stm;
    frame_tick = ft; x = 10'(px); y = 9'(py);
    model_cycle(sv, sm, stv, stm, ft, px, py);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("pixel_lane", 32'(pixel_lane), 32'(e[W-1 -: LANES]));
    check("hit_pulse", 32'(hit_pulse), 32'(e[2*LANES:LANES+1]));
    check("miss_pulse", 32'(miss_pulse), 32'(e[LANES:1]));
    check("spawn_ready", 32'(spawn_ready), 32'(e[0]));
    check("score", 32'(score), 32'(m_score));
    @(negedge clk);
  endtask

  task automatic idle(input int px, input int py);
    cycle(1'b0, '0, 1'b0, '0, 1'b0, px, py);
  endtask

  task automatic ticks(input int n, input int px, input int py);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, 1'b1, px, py);
  endtask

  // Reset is asserted away from the clock edge; outputs must clear at once.
  task automatic apply_reset();
    reset = 1'b0;
    #1;
    model_clear();
    check("rst_pixel_lane", 32'(pixel_lane), 32'd0);
    check("rst_hit_pulse", 32'(hit_pulse), 32'd0);
    check("rst_miss_pulse", 32'(miss_pulse), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_spawn_ready", 32'(spawn_ready), 32'd1);
    repeat (2) @(negedge clk);
    spawn_valid = 1'b0; spawn_mask = '0; strike_valid = 1'b0; strike_mask = '0;
    frame_tick = 1'b0; x = '0; y = '0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    spawn_valid = 1'b0; spawn_mask = '0; strike_valid = 1'b0; strike_mask = '0;
    frame_tick = 1'b0; x = '0; y = '0;
    @(negedge clk);
    apply_reset();

    // Spawn in lane 0, probe it, then 10 frames -> y = 10.
    cycle(1'b1, 4'b0001, 1'b0, '0, 1'b0, 170, 5);
    idle(170, 5);
    ticks(10, 170, 5);
    idle(170, 15);
    idle(170, 5);
    idle(219, 59);
    idle(220, 59);
    idle(170, 60);
    idle(169, 30);

    // Fill lane 2: the 9th spawn is refused; misses free it again.
    for (int i = 0; i < 9; i++) cycle(1'b1, 4'b0100, 1'b0, '0, 1'b0, 370, 0);
    check("lane2_full_ready", 32'(spawn_ready), 32'd0);
    ticks(480, 370, 470);
    check("lane2_after_miss_ready", 32'(spawn_ready), 32'd1);

    // Note reaching the bottom edge misses for exactly one cycle.
    apply_reset();
    cycle(1'b1, 4'b0001, 1'b0, '0, 1'b0, 0, 0);
    ticks(479, 170, 478);
    idle(170, 479);
    idle(170, 478);
    ticks(1, 170, 479);
    idle(170, 479);

    // Strike with coincident frame: 410 is hit, 390 moves to 391.
    apply_reset();
    cycle(1'b1, 4'b0010, 1'b0, '0, 1'b0, 0, 0);
    ticks(20, 270, 0);
    cycle(1'b1, 4'b0010, 1'b0, '0, 1'b0, 0, 0);
    ticks(390, 270, 400);
    cycle(1'b0, '0, 1'b1, 4'b0010, 1'b1, 270, 415);
    idle(270, 391);
    idle(270, 390);
    idle(270, 459);

    // Strike on empty lane 3, then a two-lane simultaneous hit.
    cycle(1'b0, '0, 1'b1, 4'b1000, 1'b0, 470, 400);
    apply_reset();
    cycle(1'b1, 4'b0011, 1'b0, '0, 1'b0, 0, 0);
    ticks(410, 170, 420);
    cycle(1'b0, '0, 1'b1, 4'b0011, 1'b0, 270, 420);
    idle(0, 0);
    idle(0, 0);

    // Reset mid-flight with three live notes and frame ticks running.
    apply_reset();
    cycle(1'b1, 4'b0111, 1'b0, '0, 1'b0, 0, 0);
    ticks(5, 170, 10);
    frame_tick = 1'b1;
    apply_reset();
    idle(170, 10);

    // Randomized traffic with one mid-run reset.
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) apply_reset();
      cycle($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)),
            $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)),
            $urandom_range(0, 2) != 0,
            int'($urandom_range(160, 560)), int'($urandom_range(0, 511)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
